// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC acquisition sequencer: state encoding,
// default widths and the shortest conversion period the ADC tolerates.
package adc_ctrl_pkg;

    localparam int DATA_W_DEFAULT    = 16;
    localparam int CNT_W_DEFAULT     = 16;
    localparam int SAMPLE_PERIOD_MIN = 40;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DRAIN     = 2'd3
    } acq_state_e;

endpackage

// File: rtl/adc_acq_sequencer_if.sv
// Bundle of every non-clock signal of the acquisition sequencer.
// master = the sequencer itself, slave = its environment (control,
// adc_interface and the downstream sample consumer).
//
// Sample handshake: a sample transfers on a rising clk edge where
// smp_valid_p and smp_ready_p are both high. Once smp_valid_p is raised,
// smp_data_p and smp_last_p stay stable until that transfer happens (or the
// burst is abandoned by abort, timeout or reset). smp_ready_p may change
// freely and is allowed to depend on smp_valid_p.
interface adc_acq_sequencer_if
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    logic              arm_p;
    logic              abort_p;
    logic [DATA_W-1:0] threshold_p;
    logic              adc_start_p;
    logic              adc_data_received_p;
    logic [DATA_W-1:0] adc_data_in_p;
    logic              smp_valid_p;
    logic [DATA_W-1:0] smp_data_p;
    logic              smp_last_p;
    logic              smp_ready_p;
    logic              busy_p;
    logic              done_p;
    logic              overrun_p;
    logic              timeout_p;
    acq_state_e        state_dbg;

    modport master (
        input  arm_p, abort_p, threshold_p,
        input  adc_data_received_p, adc_data_in_p, smp_ready_p,
        output adc_start_p, smp_valid_p, smp_data_p, smp_last_p,
        output busy_p, done_p, overrun_p, timeout_p, state_dbg
    );

    modport slave (
        output arm_p, abort_p, threshold_p,
        output adc_data_received_p, adc_data_in_p, smp_ready_p,
        input  adc_start_p, smp_valid_p, smp_data_p, smp_last_p,
        input  busy_p, done_p, overrun_p, timeout_p, state_dbg
    );

endinterface

// File: rtl/adc_period_timer.sv
// Conversion-start generator: a reloadable down-counter that fires start_p
// every SAMPLE_PERIOD cycles while enabled, plus a watchdog that flags a
// start falling due while the previous conversion result is still missing.
// While disabled the counter sits at 0, so the first start comes on the
// first enabled cycle.
module adc_period_timer
    import adc_ctrl_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 210,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic received,
    output logic start_p,
    output logic timeout_p
);

    // Periods shorter than the ADC can convert are pulled up to the minimum.
    localparam int PERIOD_C = (SAMPLE_PERIOD < SAMPLE_PERIOD_MIN) ? SAMPLE_PERIOD_MIN : SAMPLE_PERIOD;
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(PERIOD_C - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             outstanding_q, outstanding_d;
    logic             due;

    // Counter reload/decrement, start/timeout decision and outstanding flag.
    always_comb begin
        cnt_d         = '0;
        outstanding_d = 1'b0;
        due           = 1'b0;
        start_p       = 1'b0;
        timeout_p     = 1'b0;
        if (enable) begin
            due       = (cnt_q == '0);
            // A result arriving in the same cycle clears the flag first.
            timeout_p = due && outstanding_q && !received;
            start_p   = due && !timeout_p;
            cnt_d     = due ? RELOAD_C : cnt_q - 1'b1;
            if (start_p) begin
                outstanding_d = 1'b1;
            end else if (received) begin
                outstanding_d = 1'b0;
            end else begin
                outstanding_d = outstanding_q;
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            outstanding_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: rtl/adc_acq_sequencer.sv
// Triggered ADC acquisition: paces conversions, waits for a word at or
// above the armed threshold, captures a fixed-length burst (time based,
// words are dropped rather than stalling) and hands the samples downstream
// through a single-entry output register.
module adc_acq_sequencer
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEFAULT,
    parameter int SAMPLE_PERIOD = 210,
    parameter int CAPTURE_LEN   = 1024,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic                clk210_p,
    input  logic                reset_p,
    adc_acq_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] CAP_LEN_C = CNT_W'(CAPTURE_LEN);
    localparam logic             LEN_ONE_C = (CAPTURE_LEN == 1);

    acq_state_e        state_q, state_d;
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic              tmr_en;
    logic              tmr_start;
    logic              tmr_timeout;
    logic              accept;
    logic              take;
    logic              take_last;
    logic [CNT_W-1:0]  smp_cnt_inc;
    logic              cap_last;

    assign accept      = valid_q && bus.smp_ready_p;
    assign smp_cnt_inc = smp_cnt_q + 1'b1;
    assign cap_last    = (smp_cnt_inc == CAP_LEN_C);
    // An abort in the same cycle also suppresses any start that falls due.
    assign tmr_en      = ((state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE)) && !bus.abort_p;

    adc_period_timer #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk       (clk210_p),
        .rst       (reset_p),
        .enable    (tmr_en),
        .received  (bus.adc_data_received_p),
        .start_p   (tmr_start),
        .timeout_p (tmr_timeout)
    );

    // Next-state, sample capture, output register and sticky flag logic.
    always_comb begin
        state_d   = state_q;
        thr_d     = thr_q;
        smp_cnt_d = smp_cnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        take      = 1'b0;
        take_last = 1'b0;

        if (accept) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.arm_p && !bus.abort_p) begin
                    thr_d     = bus.threshold_p;
                    overrun_d = 1'b0;
                    timeout_d = 1'b0;
                    smp_cnt_d = '0;
                    state_d   = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (bus.adc_data_received_p && (bus.adc_data_in_p >= thr_q)) begin
                    take      = 1'b1;
                    take_last = LEN_ONE_C;
                    smp_cnt_d = CNT_W'(1);
                    state_d   = LEN_ONE_C ? ST_DRAIN : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.adc_data_received_p) begin
                    take      = 1'b1;
                    take_last = cap_last;
                    smp_cnt_d = smp_cnt_inc;
                    if (cap_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!valid_q || accept) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Load the captured word if the register is free this cycle,
        // otherwise the word is lost and the overrun flag sticks.
        if (take) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                data_d  = bus.adc_data_in_p;
                last_d  = take_last;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (tmr_timeout) begin
            timeout_d = 1'b1;
            valid_d   = 1'b0;
            last_d    = 1'b0;
            state_d   = ST_IDLE;
        end

        // Abort overrides everything, including a completing drain.
        if (bus.abort_p) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State, sample and flag registers.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            state_q   <= ST_IDLE;
            thr_q     <= '0;
            smp_cnt_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            thr_q     <= thr_d;
            smp_cnt_q <= smp_cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.adc_start_p = tmr_start;
    assign bus.smp_valid_p = valid_q;
    assign bus.smp_data_p  = data_q;
    assign bus.smp_last_p  = last_q;
    assign bus.busy_p      = (state_q != ST_IDLE);
    assign bus.done_p      = done_q;
    assign bus.overrun_p   = overrun_q;
    assign bus.timeout_p   = timeout_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer: one instance with a 4-sample burst
// driven by an ADC model answering 30 cycles after each start, and one
// instance with a 1-sample burst driven by hand.
module tb_adc_acq_sequencer;
    import adc_ctrl_pkg::*;

    localparam int DW = 16;
    localparam int SP = 50;
    localparam int CL = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adc_acq_sequencer_if #(.DATA_W(DW)) bus0 ();
    adc_acq_sequencer_if #(.DATA_W(DW)) bus1 ();

    adc_acq_sequencer #(.DATA_W(DW), .SAMPLE_PERIOD(SP), .CAPTURE_LEN(CL), .CNT_W(16)) dut0 (
        .clk210_p (clk),
        .reset_p  (rst),
        .bus      (bus0.master)
    );

    adc_acq_sequencer #(.DATA_W(DW), .SAMPLE_PERIOD(SP), .CAPTURE_LEN(1), .CNT_W(16)) dut1 (
        .clk210_p (clk),
        .reset_p  (rst),
        .bus      (bus1.master)
    );

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q[$];

    int cyc = 0;
    int arm_cyc = 0;
    int run_starts = 0;
    int last_start_cyc = 0;
    int start_cnt0 = 0;
    int start_cnt1 = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int recv_due = -1;
    int widx = 0;
    int withhold_n = -1;
    logic [DW-1:0] words [6];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pop one expected sample and compare it with what is being accepted.
    task automatic sb_pop(string tag, logic last, logic [DW-1:0] data);
        logic [DW:0] e;
        check({tag, "_sb_entry"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, 32'({last, data}), 32'(e));
        end
    endtask

    // One clock: observe this cycle (transfers happen at the coming edge),
    // move to the next negedge, then drive the ADC model for the new cycle.
    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            if (bus0.adc_start_p) begin
                start_cnt0++;
                run_starts++;
                if (run_starts == 1) check("first_start_latency", 32'(cyc - arm_cyc), 32'd1);
                else check("start_spacing", 32'(cyc - last_start_cyc), 32'(SP));
                last_start_cyc = cyc;
                if (run_starts != withhold_n) recv_due = cyc + 30;
            end
            if (bus0.done_p) done_cnt0++;
            if (bus0.smp_valid_p && bus0.smp_ready_p) sb_pop("smp0", bus0.smp_last_p, bus0.smp_data_p);
            if (bus1.adc_start_p) start_cnt1++;
            if (bus1.done_p) done_cnt1++;
            if (bus1.smp_valid_p && bus1.smp_ready_p) sb_pop("smp1", bus1.smp_last_p, bus1.smp_data_p);
            @(negedge clk);
            cyc++;
            if (cyc == recv_due) begin
                bus0.adc_data_received_p = 1'b1;
                bus0.adc_data_in_p       = words[widx % 6];
                widx++;
            end else begin
                bus0.adc_data_received_p = 1'b0;
            end
        end
    endtask

    task automatic step_to(int c);
        while (cyc < c) step(1);
    endtask

    task automatic arm0(logic [DW-1:0] thr);
        bus0.threshold_p = thr;
        bus0.arm_p = 1'b1;
        arm_cyc = cyc;
        run_starts = 0;
        widx = 0;
        step(1);
        bus0.arm_p = 1'b0;
    endtask

    task automatic push_burst();
        exp_q.push_back({1'b0, 16'h8000});
        exp_q.push_back({1'b0, 16'h8001});
        exp_q.push_back({1'b0, 16'h8002});
        exp_q.push_back({1'b1, 16'h8003});
    endtask

    task automatic check_zero0(string tag);
        check({tag, "_start"},   32'(bus0.adc_start_p), 32'd0);
        check({tag, "_valid"},   32'(bus0.smp_valid_p), 32'd0);
        check({tag, "_data"},    32'(bus0.smp_data_p),  32'd0);
        check({tag, "_last"},    32'(bus0.smp_last_p),  32'd0);
        check({tag, "_busy"},    32'(bus0.busy_p),      32'd0);
        check({tag, "_done"},    32'(bus0.done_p),      32'd0);
        check({tag, "_overrun"}, 32'(bus0.overrun_p),   32'd0);
        check({tag, "_timeout"}, 32'(bus0.timeout_p),   32'd0);
    endtask

    initial begin
        int d;
        int s;
        words = '{16'h0100, 16'h0200, 16'h8000, 16'h8001, 16'h8002, 16'h8003};
        rst = 1'b1;
        bus0.arm_p = 1'b0; bus0.abort_p = 1'b0; bus0.threshold_p = '0;
        bus0.adc_data_received_p = 1'b0; bus0.adc_data_in_p = '0; bus0.smp_ready_p = 1'b1;
        bus1.arm_p = 1'b0; bus1.abort_p = 1'b0; bus1.threshold_p = '0;
        bus1.adc_data_received_p = 1'b0; bus1.adc_data_in_p = '0; bus1.smp_ready_p = 1'b1;
        @(negedge clk);
        step(3);
        rst = 1'b0;
        step(1);
        check_zero0("reset");
        check("reset_state", 32'(bus0.state_dbg), 32'(ST_IDLE));

        // 1: normal burst with downstream always ready
        push_burst();
        d = done_cnt0;
        arm0(16'h4000);
        check("t1_busy_armed", 32'(bus0.busy_p), 32'd1);
        step_to(arm_cyc + 300);
        check("t1_done_count", 32'(done_cnt0 - d), 32'd1);
        check("t1_start_count", 32'(run_starts), 32'd6);
        check("t1_busy_after", 32'(bus0.busy_p), 32'd0);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t1_overrun", 32'(bus0.overrun_p), 32'd0);
        step($urandom_range(35, 60));

        // 2: downstream stalled for the whole burst
        bus0.smp_ready_p = 1'b0;
        exp_q.push_back({1'b0, 16'h8000});
        d = done_cnt0;
        arm0(16'h4000);
        step_to(arm_cyc + 300);
        check("t2_held_valid", 32'(bus0.smp_valid_p), 32'd1);
        check("t2_held_data", 32'(bus0.smp_data_p), 32'h8000);
        check("t2_held_last", 32'(bus0.smp_last_p), 32'd0);
        check("t2_overrun", 32'(bus0.overrun_p), 32'd1);
        check("t2_state_drain", 32'(bus0.state_dbg), 32'(ST_DRAIN));
        check("t2_no_done_yet", 32'(done_cnt0 - d), 32'd0);
        check("t2_start_count", 32'(run_starts), 32'd6);
        bus0.smp_ready_p = 1'b1;
        step(3);
        check("t2_done_count", 32'(done_cnt0 - d), 32'd1);
        check("t2_busy_after", 32'(bus0.busy_p), 32'd0);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        step($urandom_range(35, 60));

        // 3: second conversion never answered
        withhold_n = 2;
        d = done_cnt0;
        arm0(16'h4000);
        check("t3_overrun_cleared", 32'(bus0.overrun_p), 32'd0);
        step_to(arm_cyc + 110);
        check("t3_timeout", 32'(bus0.timeout_p), 32'd1);
        check("t3_state_idle", 32'(bus0.state_dbg), 32'(ST_IDLE));
        check("t3_start_count", 32'(run_starts), 32'd2);
        check("t3_no_done", 32'(done_cnt0 - d), 32'd0);
        check("t3_valid", 32'(bus0.smp_valid_p), 32'd0);
        withhold_n = -1;
        step($urandom_range(35, 60));

        // 4: abort after two samples (arm also clears the timeout)
        exp_q.push_back({1'b0, 16'h8000});
        exp_q.push_back({1'b0, 16'h8001});
        arm0(16'h4000);
        check("t4_timeout_cleared", 32'(bus0.timeout_p), 32'd0);
        step_to(arm_cyc + 190);
        check("t4_state_capture", 32'(bus0.state_dbg), 32'(ST_CAPTURE));
        bus0.abort_p = 1'b1;
        step(1);
        bus0.abort_p = 1'b0;
        check("t4_busy", 32'(bus0.busy_p), 32'd0);
        check("t4_valid", 32'(bus0.smp_valid_p), 32'd0);
        step(150);
        check("t4_start_count", 32'(run_starts), 32'd4);
        check("t4_no_done", 32'(done_cnt0 - d), 32'd0);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5a: arm and abort together from IDLE
        s = start_cnt0;
        bus0.arm_p = 1'b1;
        bus0.abort_p = 1'b1;
        step(1);
        bus0.arm_p = 1'b0;
        bus0.abort_p = 1'b0;
        step(10);
        check("t5a_busy", 32'(bus0.busy_p), 32'd0);
        check("t5a_no_start", 32'(start_cnt0 - s), 32'd0);
        step($urandom_range(35, 60));

        // 5b: arm during CAPTURE is ignored
        push_burst();
        d = done_cnt0;
        arm0(16'h4000);
        step_to(arm_cyc + 200);
        bus0.threshold_p = 16'hFFFF;
        bus0.arm_p = 1'b1;
        step(1);
        bus0.arm_p = 1'b0;
        step_to(arm_cyc + 300);
        check("t5b_done_count", 32'(done_cnt0 - d), 32'd1);
        check("t5b_start_count", 32'(run_starts), 32'd6);
        check("t5b_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t5b_busy_after", 32'(bus0.busy_p), 32'd0);
        step($urandom_range(35, 60));

        // 6a: reset mid-CAPTURE with a held sample and overrun set
        bus0.smp_ready_p = 1'b0;
        arm0(16'h4000);
        step_to(arm_cyc + 190);
        check("t6_pre_valid", 32'(bus0.smp_valid_p), 32'd1);
        check("t6_pre_overrun", 32'(bus0.overrun_p), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_zero0("t6_reset");
        bus0.smp_ready_p = 1'b1;
        step(40);

        // 6b: one-sample burst, the trigger word is also the last
        exp_q.push_back({1'b1, 16'h9000});
        bus1.threshold_p = 16'h4000;
        bus1.arm_p = 1'b1;
        step(1);
        bus1.arm_p = 1'b0;
        check("t6b_first_start", 32'(bus1.adc_start_p), 32'd1);
        step(2);
        bus1.adc_data_received_p = 1'b1;
        bus1.adc_data_in_p = 16'h1000;
        step(1);
        bus1.adc_data_received_p = 1'b0;
        step(1);
        check("t6b_below_thr", 32'(bus1.smp_valid_p), 32'd0);
        bus1.adc_data_received_p = 1'b1;
        bus1.adc_data_in_p = 16'h9000;
        step(1);
        bus1.adc_data_received_p = 1'b0;
        check("t6b_valid", 32'(bus1.smp_valid_p), 32'd1);
        check("t6b_last", 32'(bus1.smp_last_p), 32'd1);
        check("t6b_state_drain", 32'(bus1.state_dbg), 32'(ST_DRAIN));
        step(60);
        check("t6b_done_count", 32'(done_cnt1), 32'd1);
        check("t6b_start_count", 32'(start_cnt1), 32'd1);
        check("t6b_busy_after", 32'(bus1.busy_p), 32'd0);
        check("t6b_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_acq_sequencer.md
Name: adc_acq_sequencer

Overview:
Sequences the ADC serial interface block for triggered acquisitions.
- Issues conversion-start pulses at a fixed sample period.
- Watches each deserialized word for a threshold trigger, then captures a fixed-length burst.
- Presents the burst to downstream logic over a valid/ready handshake.
- Sits between adc_interface and the sample buffer/packetizer, and reports overrun and timeout faults.

Parameters:
DATA_W, 16, ADC word width
SAMPLE_PERIOD, 210, clock cycles between conversion starts (1 MS/s at 210 MHz); legal range 40..65535
CAPTURE_LEN, 1024, samples per burst including trigger sample; legal range 1..65535
CNT_W, 16, width of period/sample counters

Ports:
clk210_p  in  1  210 MHz clock
reset_p  in  1  synchronous, active-high reset
arm_p  in  1  one-cycle request to start an acquisition
abort_p  in  1  one-cycle request to cancel the acquisition
threshold_p  in  DATA_W  unsigned trigger level, latched on accepted arm
adc_start_p  out  1  one-cycle conversion request to adc_interface
adc_data_received_p  in  1  one-cycle strobe: adc_data_in_p holds a new word
adc_data_in_p  in  DATA_W  word from adc_interface
smp_valid_p  out  1  output sample valid
smp_data_p  out  DATA_W  output sample
smp_last_p  out  1  marks final sample of burst (qualified by smp_valid_p)
smp_ready_p  in  1  downstream accepts the sample when smp_valid_p and smp_ready_p are both high
busy_p  out  1  high in any state other than IDLE
done_p  out  1  one-cycle pulse on normal burst completion
overrun_p  out  1  sticky: a captured word was dropped
timeout_p  out  1  sticky: conversion result missing

Behaviour:
- Clocking and reset: single clock clk210_p. reset_p is synchronous and active-high. On reset the state is IDLE and every output is 0; counters and the latched threshold are also 0.
- States: IDLE, WAIT_TRIG, CAPTURE, DRAIN.
- IDLE:
  - No adc_start_p is issued; adc_data_received_p is ignored.
  - An accepted arm_p latches threshold_p, clears overrun_p and timeout_p, loads the period counter with 0, and moves to WAIT_TRIG.
- Period timer (WAIT_TRIG and CAPTURE only):
  - When the counter is 0, assert adc_start_p and reload SAMPLE_PERIOD-1; otherwise decrement.
  - The first adc_start_p occurs on the first cycle in WAIT_TRIG. Starts then repeat every SAMPLE_PERIOD cycles exactly.
- Watchdog:
  - An "outstanding" flag is set on each adc_start_p and cleared by adc_data_received_p.
  - If adc_start_p is due while the flag is still set: set timeout_p, suppress that start, clear smp_valid_p, go to IDLE. done_p is not pulsed.
  - adc_data_received_p in the same cycle as a due start clears the flag first, so no timeout fires.
- WAIT_TRIG: on a received word with adc_data_in_p >= latched threshold (unsigned), that word becomes sample 1 and the state moves to CAPTURE. Words below threshold are discarded.
- CAPTURE: every received word becomes the next sample and the sample counter increments.
  - When sample count == CAPTURE_LEN, that word carries smp_last_p and the state moves to DRAIN.
  - CAPTURE_LEN=1: the trigger word carries smp_last_p and the state goes directly WAIT_TRIG->DRAIN.
- Output register (single entry):
  - The sample is registered: smp_valid_p rises the cycle after the accepted adc_data_received_p.
  - The register is held stable until accepted.
  - A new word arriving while smp_valid_p=1 and smp_ready_p=0 is dropped and overrun_p is set. The sample count still increments, so burst length is time-based. If the dropped word is the last one, smp_last_p is lost but the state still moves to DRAIN.
  - A new word arriving in the same cycle as an accept is loaded with no drop.
- DRAIN: no starts. Once the output register is empty (or accepted this cycle): pulse done_p and go to IDLE.
- abort_p: from any state, next state is IDLE, smp_valid_p and smp_last_p are cleared, and done_p is not pulsed.
- Simultaneous and ignored requests:
  - abort_p and arm_p in the same cycle: abort wins, so no arm is accepted.
  - arm_p while busy_p is high is ignored.
- Sticky flags hold until the next accepted arm or reset.

Decomposition:
- Package adc_ctrl_pkg holds:
  - the state encoding (IDLE/WAIT_TRIG/CAPTURE/DRAIN);
  - the DATA_W and CNT_W defaults;
  - SAMPLE_PERIOD_MIN=40.
- One sub-module, adc_period_timer. It contains the reloadable period down-counter plus the outstanding/timeout watchdog. Its signals are enable in, start_p out, received in, and timeout_p out.

Test Plan:
- Bench: SAMPLE_PERIOD=50, CAPTURE_LEN=4, smp_ready_p=1, ADC model returns a word 30 cycles after each start; words 0x0100, 0x0200, 0x8000, 0x8001, 0x8002, 0x8003.
1. arm with threshold 0x4000 -> first start on cycle after arm, starts every 50 cycles; samples 0x8000..0x8003 emitted, last on 0x8003; done_p one pulse; busy_p low after; exactly 6 starts.
2. Same as 1 with smp_ready_p held 0 -> 0x8000 held on smp_data_p, words 2–4 dropped, overrun_p=1; raise ready -> one accept, then done_p.
3. ADC model withholds response to 2nd start -> timeout_p=1 at 3rd start time, no 3rd start, state IDLE, done_p stays 0; next arm clears timeout_p.
4. abort_p mid-CAPTURE after 2 samples -> IDLE next cycle, smp_valid_p=0, no further starts, no done_p.
5. arm_p and abort_p in same cycle from IDLE -> stays IDLE, no starts. arm_p during CAPTURE -> ignored, burst unaffected.
6. reset_p asserted for 1 cycle mid-CAPTURE with smp_valid_p=1 -> all outputs 0 next cycle, sticky flags cleared; CAPTURE_LEN=1 run -> trigger word carries smp_last_p.
